// File: rtl/agc_symb_sched.sv
// Symbol-level round-robin scheduler sharing one AGC unpack datapath between
// NUM_REQ antenna-group buffers; one full symbol per grant, then EOP + guard.
module agc_symb_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SYM_BEATS   = 32,
  parameter int GUARD_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_rready,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [2:0]         o_sel,
  output logic               o_rd_en,
  output logic               o_symb_eop,
  output logic               o_busy,
  output logic               o_err_timeout,
  output logic [15:0]        o_sym_cnt
);

  localparam int BW = $clog2(SYM_BEATS + 1);
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_READ, S_EOP, S_GUARD} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [SW-1:0]      stall_q, stall_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;

  // Round-robin search starting one past the last winner.
  logic [7:0] req_pad;
  logic       win_vld;
  logic [2:0] win_idx;
  logic [3:0] cand;
  always_comb begin
    req_pad = 8'(i_req);
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_vld && req_pad[cand[2:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    guard_d = guard_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d   = win_idx;
          ptr_d   = win_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        beat_d  = '0;
        stall_d = '0;
        state_d = S_READ;
      end
      S_READ: begin
        // A beat on the would-be timeout cycle wins over the abort.
        if (i_rready) begin
          beat_d  = beat_q + 1'b1;
          stall_d = '0;
          if (beat_q == BW'(SYM_BEATS - 1)) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = S_EOP;
          end
        end else if (stall_q == SW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_EOP;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      S_EOP: begin
        gnt_d   = '0;
        guard_d = '0;
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q == GW'(GUARD_CYC - 1)) begin
          if (win_vld) begin
            gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            sel_d   = win_idx;
            ptr_d   = win_idx;
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= 3'(NUM_REQ - 1);
      beat_q  <= '0;
      stall_q <= '0;
      guard_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      guard_q <= guard_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_gnt         = gnt_q;
  assign o_sel         = sel_q;
  assign o_rd_en       = (state_q == S_READ) && i_rready;
  assign o_symb_eop    = (state_q == S_EOP);
  assign o_busy        = (state_q != S_IDLE);
  assign o_err_timeout = err_q;
  assign o_sym_cnt     = cnt_q;

endmodule

// File: doc/agc_symb_sched.md
Name: agc_symb_sched

Overview:
- Symbol-level round-robin scheduler that shares one AGC unpack datapath between NUM_REQ antenna-group requesters.
- Each requester raises a request once a full symbol of SYM_BEATS beats is buffered.
- The scheduler grants one requester and drives its read enable for exactly SYM_BEATS accepted beats. It then emits the symbol-end pulse the datapath uses to reset its min-AGC search, and inserts guard cycles so the datapath pipeline drains before the next symbol.
- It sits between the per-group symbol buffers and the AGC unpack block, and drives its data mux select.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SYM_BEATS, 32, beats per symbol; must match the datapath search depth.
- GUARD_CYC, 4, idle cycles after the symbol-end pulse (>=1).
- TIMEOUT_CYC, 64, maximum consecutive stalled cycles in READ before the symbol is aborted.

Ports:
- i_clk, in, 1, clock.
- i_reset, in, 1, synchronous active-high reset.
- i_req, in, NUM_REQ, per-requester "symbol ready", level; held until granted.
- i_rready, in, 1, downstream ready; 0 stalls reading.
- o_gnt, out, NUM_REQ, one-hot grant.
- o_sel, out, 3, binary index of the granted requester (mux select).
- o_rd_en, out, 1, read strobe to the granted requester's buffer and beat-valid to the datapath.
- o_symb_eop, out, 1, one-cycle symbol-end pulse to the datapath.
- o_busy, out, 1, high in any state other than IDLE.
- o_err_timeout, out, 1, one-cycle pulse on abort.
- o_sym_cnt, out, 16, count of completed (non-aborted) symbols; wraps.

Behaviour:
- Reset values:
  - State IDLE; o_gnt=0, o_sel=0, o_rd_en=0, o_symb_eop=0, o_busy=0, o_err_timeout=0, o_sym_cnt=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Beat and stall counters = 0.
- State machine:
  - IDLE, if any i_req: pick winner, register o_gnt/o_sel, go to GRANT.
  - GRANT: lasts 1 cycle (select settles), then READ; beat counter = 0.
  - READ: o_rd_en = i_rready. This is the only combinational input-to-output path; all other outputs are registered or decoded from state.
    - Each cycle with o_rd_en=1: beat_cnt++ and stall_cnt = 0.
    - Each cycle with i_rready=0: stall_cnt++.
    - Accepted beat with beat_cnt==SYM_BEATS-1: go to EOP, o_sym_cnt++.
    - stall_cnt==TIMEOUT_CYC-1 while still stalled: go to EOP, pulse o_err_timeout, no o_sym_cnt increment.
  - EOP: lasts 1 cycle, o_symb_eop=1. o_gnt is still held, then cleared on exit. Go to GUARD with guard_cnt=0.
  - GUARD: lasts GUARD_CYC cycles, o_gnt=0. On the last cycle, if any i_req, arbitrate and go directly to GRANT; otherwise go to IDLE.
- Arbitration:
  - Round-robin; search starts at pointer+1 modulo NUM_REQ.
  - Pointer is updated to the winner when GRANT is entered.
  - Requests are sampled only in IDLE and on the last GUARD cycle.
  - Request changes during GRANT/READ/EOP are ignored.
  - A granted requester dropping i_req mid-symbol does not shorten the symbol.
- Latency:
  - i_req sampled in IDLE at cycle t gives o_gnt at t+1 and the first possible o_rd_en at t+2.
  - Unstalled symbol period back-to-back = 1+SYM_BEATS+1+GUARD_CYC = 38 cycles at defaults.
- Boundaries:
  - o_gnt is always one-hot or zero.
  - o_rd_en is never high outside READ and never more than SYM_BEATS times per grant.
  - o_sym_cnt wraps from 0xFFFF to 0.
  - i_reset mid-READ: next cycle is IDLE with all outputs at reset values, counters cleared, no o_symb_eop emitted.
  - i_req=0 everywhere: stays in IDLE indefinitely.
  - A stall ending on the same cycle the timeout would fire (i_rready=1) counts as a beat, not an abort.

Test Plan:
- Single request:
  - Stimulus: i_req=4'b0001 at cycle 0, i_rready=1.
  - Required: o_gnt=0001 at cycle 1; o_rd_en high cycles 2..33 (32 beats); o_symb_eop at cycle 34; o_busy low at cycle 39; o_sym_cnt=1.
- Round-robin:
  - Stimulus: i_req=4'b1111 held.
  - Required: grant order 0,1,2,3,0; consecutive grants 38 cycles apart; o_sel 0,1,2,3,0.
- Backpressure:
  - Stimulus: i_rready low for 10 cycles after beat 5.
  - Required: exactly 32 o_rd_en beats; o_symb_eop 10 cycles later than the unstalled case; no o_err_timeout.
- Timeout:
  - Stimulus: i_rready held low from beat 3.
  - Required: o_err_timeout and o_symb_eop pulse 64 stalled cycles later; o_sym_cnt unchanged; next requester granted after guard.
- Reset mid-symbol:
  - Stimulus: i_reset at beat 20 with i_req=0011.
  - Required: outputs zero next cycle with no eop. After release, requester 0 is granted first (pointer reset).
- Late request and counter wrap:
  - Stimulus: i_req[2] raised during READ of requester 1, with o_sym_cnt preloaded near wrap via 65536 symbols.
  - Required: requester 2 granted directly from the last GUARD cycle; o_sym_cnt wraps to 0.
